first_n_of_m_seq: RTL and testbench
===================================

// Module: first_n_of_m_seq
// PURPOSE
//  Parametrised, sequential successor of the fixed first-8-of-1536 encoder. On a start strobe it latches an
//  NBITS-wide VFAT hit/cluster flag vector and reports the addresses of the first NOUT set bits, LSB first.
//  It extracts NPERCYC addresses per clock4x cycle, so a wide vector is encoded in a short fixed-latency job.
//  It sits between the cluster-flag stage and the cluster packer.
// PARAMETERS
//  NBITS    1536                  width of the input flag vector
//  NOUT     8                     number of addresses reported per job
//  NPERCYC  2                     addresses extracted per scan cycle; NOUT % NPERCYC must be 0
//  ADRB     $clog2(NBITS+1) (=11) address width; all-ones (2047) is the invalid marker
// PORTS
//  clock4x       in   1            sole clock, all logic on the rising edge
//  global_reset  in   1            synchronous, active-high reset
//  start         in   1            job request; sampled only when busy=0
//  vpfs          in   NBITS        flag vector; latched on the accepted-start edge
//  busy          out  1            high while a job is scanning
//  done          out  1            one-cycle pulse; adr/vld/overflow updated in this cycle
//  adr           out  NOUT*ADRB    slot i = adr[i*ADRB +: ADRB]; address of the i-th lowest set bit
//  vld           out  NOUT         vld[i]=1 when slot i holds a real address
//  overflow      out  1            more than NOUT bits were set in the latched vector
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, vld=0, overflow=0; every adr slot=all-ones; work register=0.
//  - FSM IDLE->SCAN on start&!busy. The edge latches vpfs into work, clears the internal slot index and
//    pending results, and sets busy=1.
//  - SCAN: fixed NOUT/NPERCYC cycles, independent of hit count. Each cycle takes the NPERCYC lowest set bits
//    of work (priority chain, lowest index wins), writes them to the next NPERCYC pending slots with vld=1,
//    and clears them in work. If fewer bits remain, the unused slots get adr=all-ones and vld=0.
//  - After the last scan cycle: FSM->IDLE, busy=0, done=1 for one cycle.
//  - At the same edge, the pending slots are copied atomically to adr/vld, and overflow=|work (residue).
//  - Latency: start accepted at edge t -> done high in the cycle after edge t+NOUT/NPERCYC
//    (defaults: t+4, i.e. 5 cycles per job).
//  - Outputs hold their values between done pulses. They never show partial results.
//  - start with busy=1 is ignored, with no queueing. start in the done cycle is accepted (back-to-back jobs).
//  - vpfs changes after the latch edge do not affect the running job.
//  - vpfs=0: the job still runs full length; done pulses with vld=0, all adr=all-ones, overflow=0.
//  - Exactly NOUT bits set: all vld=1, overflow=0. NOUT+1 or more set: first NOUT reported, overflow=1.
//  - Top bit (index NBITS-1) is reportable: adr=NBITS-1, which is distinct from the invalid marker.
//  - global_reset mid-SCAN: the job is aborted, no done pulse, outputs return to reset values next cycle.
//    global_reset wins over a simultaneous start.
//  - vld is monotonic per job: vld[i]=0 implies vld[j]=0 for all j>i. Valid addresses strictly increase
//    with slot index.
// TESTING
//  1 vpfs=0xFF, start -> done after 5 cycles; adr0..7=0..7, vld=8'hFF, overflow=0.
//  2 vpfs=0xFF00 then 0xFF0000 back-to-back (start in the done cycle) -> adr 8..15, then 16..23;
//    dones 5 cycles apart.
//  3 vpfs bits {0,1535} -> adr0=0, adr1=1535, adr2..7=2047, vld=8'h03, overflow=0.
//  4 vpfs bits 0..8 -> adr0..7=0..7, vld=8'hFF, overflow=1. Bits {3,700} plus 9 bits above 1000 ->
//    adr0=3, adr1=700, overflow=1.
//  5 start again 2 cycles into a job with new vpfs -> ignored; the first job's results are unchanged.
//    vpfs=0 -> vld=0, all adr=2047.
//  6 global_reset at scan cycle 2 -> no done; vld=0 and adr=2047 next cycle; a new start after reset
//    gives a correct job.

Source files
------------

// File: rtl/first_n_of_m_seq.sv
// Sequential first-NOUT-of-NBITS address encoder.
// A start strobe latches the flag vector. Each scan cycle then extracts NPERCYC addresses, lowest index first.
module first_n_of_m_seq #(
    parameter int unsigned NBITS   = 1536,
    parameter int unsigned NOUT    = 8,
    parameter int unsigned NPERCYC = 2,
    parameter int unsigned ADRB    = $clog2(NBITS + 1)
) (
    input  logic                 clock4x,
    input  logic                 global_reset,
    input  logic                 start,
    input  logic [NBITS-1:0]     vpfs,
    output logic                 busy,
    output logic                 done,
    output logic [NOUT*ADRB-1:0] adr,
    output logic [NOUT-1:0]      vld,
    output logic                 overflow
);

    localparam int unsigned NSCAN = NOUT / NPERCYC;
    localparam int unsigned CW    = $clog2(NSCAN + 1);
    localparam logic [ADRB-1:0] ADR_INV = '1;

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [NBITS-1:0]            work_q, work_d;
    logic [NOUT-1:0][ADRB-1:0]   pend_adr_q, pend_adr_d;
    logic [NOUT-1:0]             pend_vld_q, pend_vld_d;
    logic [NOUT-1:0][ADRB-1:0]   adr_q, adr_d;
    logic [NOUT-1:0]             vld_q, vld_d;
    logic                        ovf_q, ovf_d;
    logic                        done_q, done_d;

    logic [NPERCYC-1:0][ADRB-1:0] ext_adr;
    logic [NPERCYC-1:0]           ext_vld;
    logic [NBITS-1:0]             ext_rest;
    logic                         last;

    // Priority chain: peel off the lowest set bit NPERCYC times.
    always_comb begin
        logic [NBITS-1:0] tmp;
        tmp = work_q;
        for (int k = 0; k < int'(NPERCYC); k++) begin
            ext_adr[k] = ADR_INV;
            ext_vld[k] = |tmp;
            for (int i = int'(NBITS) - 1; i >= 0; i--) begin
                if (tmp[i]) begin
                    ext_adr[k] = ADRB'(i);
                end
            end
            tmp = tmp & (tmp - NBITS'(1));
        end
        ext_rest = tmp;
    end

    assign last = (cnt_q == CW'(NSCAN - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        pend_adr_d = pend_adr_q;
        pend_vld_d = pend_vld_q;
        adr_d      = adr_q;
        vld_d      = vld_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StScan;
                    work_d     = vpfs;
                    cnt_d      = '0;
                    pend_adr_d = '1;
                    pend_vld_d = '0;
                end
            end
            StScan: begin
                work_d = ext_rest;
                cnt_d  = cnt_q + CW'(1);
                for (int s = 0; s < int'(NOUT); s++) begin
                    for (int k = 0; k < int'(NPERCYC); k++) begin
                        if (s == int'(cnt_q) * int'(NPERCYC) + k) begin
                            pend_adr_d[s] = ext_adr[k];
                            pend_vld_d[s] = ext_vld[k];
                        end
                    end
                end
                // Publish the finished slot set in one step so outputs never show a partial job.
                if (last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    adr_d   = pend_adr_d;
                    vld_d   = pend_vld_d;
                    ovf_d   = |ext_rest;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            work_q     <= '0;
            pend_adr_q <= '1;
            pend_vld_q <= '0;
            adr_q      <= '1;
            vld_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            pend_adr_q <= pend_adr_d;
            pend_vld_q <= pend_vld_d;
            adr_q      <= adr_d;
            vld_q      <= vld_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == StScan);
    assign done     = done_q;
    assign adr      = adr_q;
    assign vld      = vld_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_first_n_of_m_seq.sv
// Randomised bench for first_n_of_m_seq against a hit-list reference model.
module tb_first_n_of_m_seq;

    localparam int NBITS   = 1536;
    localparam int NOUT    = 8;
    localparam int NPERCYC = 2;
    localparam int ADRB    = $clog2(NBITS + 1);
    localparam int LAT     = NOUT / NPERCYC + 1;

    logic                 clock4x = 1'b0;
    logic                 global_reset;
    logic                 start;
    logic [NBITS-1:0]     vpfs;
    logic                 busy;
    logic                 done;
    logic [NOUT*ADRB-1:0] adr;
    logic [NOUT-1:0]      vld;
    logic                 overflow;

    int n_checks = 0;
    int n_pass   = 0;

    first_n_of_m_seq #(
        .NBITS   (NBITS),
        .NOUT    (NOUT),
        .NPERCYC (NPERCYC)
    ) dut (
        .clock4x      (clock4x),
        .global_reset (global_reset),
        .start        (start),
        .vpfs         (vpfs),
        .busy         (busy),
        .done         (done),
        .adr          (adr),
        .vld          (vld),
        .overflow     (overflow)
    );

    always #5 clock4x = ~clock4x;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: list every set index ascending, report the first NOUT.
    function automatic void model(input logic [NBITS-1:0] v, output logic [NOUT*ADRB-1:0] ea,
                                  output logic [NOUT-1:0] ev, output logic eo);
        int hits[$];
        for (int i = 0; i < NBITS; i++) if (v[i]) hits.push_back(i);
        ea = '1;
        ev = '0;
        for (int s = 0; s < NOUT; s++) begin
            if (s < hits.size()) begin
                ea[s*ADRB +: ADRB] = ADRB'(hits[s]);
                ev[s] = 1'b1;
            end
        end
        eo = (hits.size() > NOUT);
    endfunction

    function automatic logic [NBITS-1:0] rand_vec();
        logic [NBITS-1:0] v;
        int n;
        v = '0;
        n = $urandom_range(0, 12);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) v[NBITS - 1 - $urandom_range(0, 3)] = 1'b1;
            else v[$urandom_range(0, NBITS - 1)] = 1'b1;
        end
        return v;
    endfunction

    logic [NOUT*ADRB-1:0] last_ea;
    logic [NOUT-1:0]      last_ev;
    logic                 last_eo;

    // Called at a negedge; returns at the negedge where done is seen so a new job can start there.
    task automatic run_job(input logic [NBITS-1:0] v, input string tag, input int poke_at);
        int  n;
        bit  got;
        model(v, last_ea, last_ev, last_eo);
        vpfs  = v;
        start = 1'b1;
        n     = 0;
        got   = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clock4x);
            n++;
            if (n == 1) chk({tag, "_busy"}, 128'(busy), 128'(1));
            if (done) begin
                got = 1'b1;
            end else begin
                start = (n == poke_at);
                vpfs  = rand_vec();
            end
        end
        start = 1'b0;
        if (!got) begin
            chk({tag, "_timeout"}, 128'(0), 128'(1));
        end else begin
            chk({tag, "_lat"}, 128'(n), 128'(LAT));
            chk({tag, "_adr"}, 128'(adr), 128'(last_ea));
            chk({tag, "_vld"}, 128'(vld), 128'(last_ev));
            chk({tag, "_ovf"}, 128'(overflow), 128'(last_eo));
            chk({tag, "_idle"}, 128'(busy), 128'(0));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_vld"}, 128'(vld), 128'(0));
        chk({tag, "_ovf"}, 128'(overflow), 128'(0));
        chk({tag, "_adr"}, 128'(adr), {{(128 - NOUT*ADRB){1'b0}}, {(NOUT*ADRB){1'b1}}});
    endtask

    initial begin
        logic [NBITS-1:0] v;
        int dones;
        global_reset = 1'b1;
        start        = 1'b0;
        vpfs         = '0;
        repeat (3) @(negedge clock4x);
        check_reset_outputs("reset");
        global_reset = 1'b0;
        @(negedge clock4x);

        v = '0; v[7:0] = 8'hFF;
        run_job(v, "t1", 0);
        @(negedge clock4x);
        chk("t1_hold_adr", 128'(adr), 128'(last_ea));
        chk("t1_hold_done", 128'(done), 128'(0));

        v = '0; v[15:8] = 8'hFF;
        run_job(v, "t2a", 0);
        v = '0; v[23:16] = 8'hFF;
        run_job(v, "t2b", 0);

        v = '0; v[0] = 1'b1; v[NBITS-1] = 1'b1;
        run_job(v, "t3", 0);

        v = '0; v[8:0] = 9'h1FF;
        run_job(v, "t4a", 0);
        v = '0; v[3] = 1'b1; v[700] = 1'b1; v[1009:1001] = 9'h1FF;
        run_job(v, "t4b", 0);

        run_job(rand_vec() | NBITS'(1), "t5_poke", 2);
        run_job('0, "t5_zero", 0);

        v = '0; v[7:0] = 8'hF0;
        run_job(v, "t6_pre", 0);
        vpfs  = rand_vec();
        start = 1'b1;
        @(negedge clock4x);
        start = 1'b0;
        @(negedge clock4x);
        global_reset = 1'b1;
        start        = 1'b1;
        @(negedge clock4x);
        check_reset_outputs("t6_rst");
        global_reset = 1'b0;
        start        = 1'b0;
        dones        = 0;
        repeat (8) begin
            @(negedge clock4x);
            if (done) dones++;
        end
        chk("t6_no_done", 128'(dones), 128'(0));
        run_job(rand_vec(), "t6_after", 0);

        for (int j = 0; j < 30; j++) begin
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clock4x);
            run_job(rand_vec(), $sformatf("rnd%0d", j), ($urandom_range(0, 1) == 1) ? 3 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
